// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED blink sequencer: colour mode
// encoding, key command encoding and the period register width.
package led_seq_pkg;

    localparam int PERIOD_W = 32;

    typedef enum logic [1:0] {
        MODE_GREEN   = 2'd0,
        MODE_RED     = 2'd1,
        MODE_BOTH    = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_SLOWER  = 2'd1,
        CMD_FASTER  = 2'd2,
        CMD_RESTORE = 2'd3
    } cmd_t;

    // Colour rotation GREEN -> RED -> BOTH -> GREEN; the unused code falls back to RED.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_GREEN: next_mode = MODE_RED;
            MODE_RED:   next_mode = MODE_BOTH;
            MODE_BOTH:  next_mode = MODE_GREEN;
            default:    next_mode = MODE_RED;
        endcase
    endfunction

endpackage

// File: rtl/led_blink_sequencer_if.sv
// Board-facing signal bundle of the LED blink sequencer.
// Optional macro: LED_SEQ_HOLD_EN adds the HOLD freeze input.
// Handshake: there is no valid/ready pair; KEY is a raw asynchronous level and
// TICK is a one-cycle strobe with no back-pressure, so a consumer must sample
// it every cycle.
interface led_blink_sequencer_if;
    logic [2:0]  KEY;
`ifdef LED_SEQ_HOLD_EN
    logic        HOLD;
`endif
    logic [7:0]  LEDG;
    logic [9:0]  LEDR;
    logic        TICK;
    logic [1:0]  MODE;
    logic [31:0] PERIOD;

`ifdef LED_SEQ_HOLD_EN
    modport master (output KEY, output HOLD,
                    input LEDG, input LEDR, input TICK, input MODE, input PERIOD);
    modport slave  (input KEY, input HOLD,
                    output LEDG, output LEDR, output TICK, output MODE, output PERIOD);
`else
    modport master (output KEY,
                    input LEDG, input LEDR, input TICK, input MODE, input PERIOD);
    modport slave  (input KEY,
                    output LEDG, output LEDR, output TICK, output MODE, output PERIOD);
`endif
endinterface

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter and press detect.
// The debounced level follows the pin only after DEBOUNCE_CYCLES consecutive
// differing samples; a released->pressed change (1->0) emits a single-cycle
// press pulse, so a held key never repeats.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] stab_q;

    // Synchronise the pin, count stable samples, commit the level and pulse on a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            stab_q  <= '0;
            press   <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            press   <= 1'b0;
            if (sync2_q == level_q) begin
                stab_q <= '0;
            end else if (stab_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                stab_q  <= '0;
                press   <= ~sync2_q;
            end else begin
                stab_q <= stab_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_blink_sequencer.sv
// LED blink sequencer: debounced key commands adjust the blink period, a
// free-running counter produces blink ticks, and the tick stream rotates the
// colour mode GREEN -> RED -> BOTH. LEDs are registered from PHASE/MODE.
// Optional macro: LED_SEQ_HOLD_EN adds HOLD, which freezes the blink counter,
// PHASE, toggle count and MODE while key commands keep working.
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned PERIOD_RESET     = 25000000,
    parameter int unsigned PERIOD_STEP      = 12500000,
    parameter int unsigned PERIOD_MIN       = 12500000,
    parameter int unsigned PERIOD_MAX       = 250000000,
    parameter int unsigned TOGGLES_PER_MODE = 6,
    parameter int unsigned DEBOUNCE_CYCLES  = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    led_blink_sequencer_if.slave  bus
);

    localparam int TCW = $clog2(TOGGLES_PER_MODE + 1);

    logic [2:0]          press;
    logic                hold;
    cmd_t                cmd;
    logic                can_inc;
    logic                can_dec;
    logic                hit;
    logic [PERIOD_W:0]   inc_sum;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                phase_q, phase_d;
    logic [TCW-1:0]      tcount_q, tcount_d;
    mode_t               mode_q, mode_d;
    logic                tick_q, tick_d;
    logic [7:0]          ledg_q;
    logic [9:0]          ledr_q;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
            .clk   (CLOCK_50),
            .rst   (RESET),
            .key_n (bus.KEY[i]),
            .press (press[i])
        );
    end

`ifdef LED_SEQ_HOLD_EN
    assign hold = bus.HOLD;
`else
    assign hold = 1'b0;
`endif

    // 33-bit sum so the upper saturation check can never wrap.
    assign inc_sum = {1'b0, period_q} + (PERIOD_W + 1)'(PERIOD_STEP);
    assign can_inc = (inc_sum <= (PERIOD_W + 1)'(PERIOD_MAX));
    assign can_dec = (period_q >= PERIOD_W'(PERIOD_MIN + PERIOD_STEP));
    assign hit     = (cnt_q == period_q);

    // Pick one command per cycle: restore beats slower beats faster.
    always_comb begin
        cmd = CMD_NONE;
        if (press[2])      cmd = CMD_RESTORE;
        else if (press[0]) cmd = CMD_SLOWER;
        else if (press[1]) cmd = CMD_FASTER;
    end

    // Next-state for counter, period, phase and mode; an executed command
    // that clears Cnt swallows a coincident tick, a saturated one is a no-op.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        phase_d  = phase_q;
        tcount_d = tcount_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        if (mode_q == MODE_ILLEGAL) mode_d = MODE_RED;
        if (cmd == CMD_RESTORE) begin
            period_d = PERIOD_W'(PERIOD_RESET);
            mode_d   = MODE_RED;
            tcount_d = '0;
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (cmd == CMD_SLOWER && can_inc) begin
            period_d = inc_sum[PERIOD_W-1:0];
            cnt_d    = '0;
        end else if (cmd == CMD_FASTER && can_dec) begin
            period_d = period_q - PERIOD_W'(PERIOD_STEP);
            cnt_d    = '0;
        end else if (!hold) begin
            if (hit) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
                tick_d  = 1'b1;
                if (tcount_q == TCW'(TOGGLES_PER_MODE - 1)) begin
                    tcount_d = '0;
                    mode_d   = next_mode(mode_q);
                end else begin
                    tcount_d = tcount_q + TCW'(1);
                end
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    // State registers plus LED drive derived from the current PHASE/MODE.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt_q    <= '0;
            period_q <= PERIOD_W'(PERIOD_RESET);
            phase_q  <= 1'b0;
            tcount_q <= '0;
            mode_q   <= MODE_RED;
            tick_q   <= 1'b0;
            ledg_q   <= '0;
            ledr_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            tcount_q <= tcount_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            ledg_q   <= (mode_q == MODE_GREEN || mode_q == MODE_BOTH) ? {8{phase_q}} : 8'h00;
            ledr_q   <= (mode_q == MODE_RED || mode_q == MODE_BOTH) ? {10{phase_q}} : 10'h000;
        end
    end

    assign bus.LEDG   = ledg_q;
    assign bus.LEDR   = ledr_q;
    assign bus.TICK   = tick_q;
    assign bus.MODE   = mode_q;
    assign bus.PERIOD = period_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with small timing parameters
// (PERIOD_RESET=4, STEP=2, MIN=2, MAX=10, TOGGLES_PER_MODE=6, DEBOUNCE_CYCLES=3).
// The HOLD scenario is compiled only when LED_SEQ_HOLD_EN is defined.
module tb_led_blink_sequencer;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;

    // Clock / reset block
    always #5 CLOCK_50 = ~CLOCK_50;

    led_blink_sequencer_if bus();

    led_blink_sequencer #(
        .PERIOD_RESET     (4),
        .PERIOD_STEP      (2),
        .PERIOD_MIN       (2),
        .PERIOD_MAX       (10),
        .TOGGLES_PER_MODE (6),
        .DEBOUNCE_CYCLES  (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          key;
        logic [31:0] exp_period;
    } press_vec_t;

    press_vec_t vecs[10];

    // Scoreboard comparison
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance n clock edges and settle just after the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Wait for TICK, bounded; steps = edges advanced until TICK seen
    task automatic wait_tick(input int budget, output int steps, output bit ok);
        steps = 0;
        ok    = 1'b0;
        while (steps < budget && !ok) begin
            step(1);
            steps++;
            if (bus.TICK) ok = 1'b1;
        end
    endtask

    // Driver: hold one key low for low_cycles then release and let it settle
    task automatic key_press(input int idx, input int low_cycles);
        bus.KEY[idx] = 1'b0;
        step(low_cycles);
        bus.KEY[idx] = 1'b1;
        step(12);
    endtask

    function automatic logic [1:0] exp_mode(input int k);
        return 2'((1 + k / 6) % 3);
    endfunction

    function automatic logic [7:0] exp_ledg(input logic [1:0] m, input logic ph);
        return ((m == 2'd0 || m == 2'd2) && ph) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [9:0] exp_ledr(input logic [1:0] m, input logic ph);
        return ((m == 2'd1 || m == 2'd2) && ph) ? 10'h3FF : 10'h000;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  steps;
        bit  ok;
        logic [1:0] m;
        logic ph;

        vecs[0] = '{0, 32'd6};  vecs[1] = '{0, 32'd8};  vecs[2] = '{0, 32'd10};
        vecs[3] = '{0, 32'd10}; vecs[4] = '{0, 32'd10};
        vecs[5] = '{1, 32'd8};  vecs[6] = '{1, 32'd6};  vecs[7] = '{1, 32'd4};
        vecs[8] = '{1, 32'd2};  vecs[9] = '{1, 32'd2};

        bus.KEY = 3'b111;
`ifdef LED_SEQ_HOLD_EN
        bus.HOLD = 1'b0;
`endif
        RESET = 1'b1;
        step(3);
        check("reset_tick",   32'(bus.TICK),   32'd0);
        check("reset_mode",   32'(bus.MODE),   32'd1);
        check("reset_period", bus.PERIOD,      32'd4);
        check("reset_ledg",   32'(bus.LEDG),   32'd0);
        check("reset_ledr",   32'(bus.LEDR),   32'd0);
        RESET = 1'b0;

        // 18 ticks: spacing, mode rotation and LED table
        for (int k = 1; k <= 18; k++) begin
            wait_tick(20, steps, ok);
            check("tick_seen", 32'(ok), 32'd1);
            check("tick_interval", 32'(steps), (k == 1) ? 32'd5 : 32'd4);
            m  = exp_mode(k);
            ph = 1'(k % 2);
            check("tick_mode", 32'(bus.MODE), 32'(m));
            step(1);
            check("tick_ledg", 32'(bus.LEDG), 32'(exp_ledg(m, ph)));
            check("tick_ledr", 32'(bus.LEDR), 32'(exp_ledr(m, ph)));
        end

        // Period stepping with saturation at both ends
        for (int i = 0; i < 10; i++) begin
            key_press(vecs[i].key, 6);
            check("press_period", bus.PERIOD, vecs[i].exp_period);
        end

        // Restore defaults from KEY[2]
        key_press(2, 6);
        check("restore_period", bus.PERIOD, 32'd4);
        check("restore_mode",   32'(bus.MODE), 32'd1);

        // Glitch of 2 cycles is rejected
        key_press(0, 2);
        check("glitch_period", bus.PERIOD, 32'd4);

        // Long hold: one step, exactly DEBOUNCE_CYCLES+3 edges after the pin edge
        bus.KEY[0] = 1'b0;
        step(5);
        check("latency_before", bus.PERIOD, 32'd4);
        step(1);
        check("latency_at", bus.PERIOD, 32'd6);
        step(994);
        check("hold_no_repeat", bus.PERIOD, 32'd6);
        bus.KEY[0] = 1'b1;
        step(12);
        check("hold_release", bus.PERIOD, 32'd6);

        // Simultaneous KEY[0]+KEY[2] with PERIOD=8, MODE=2
        key_press(0, 6);
        check("pre_prio_period", bus.PERIOD, 32'd8);
        steps = 0;
        while (steps < 400 && bus.MODE != 2'd2) begin
            step(1);
            steps++;
        end
        check("reach_mode2", 32'(bus.MODE), 32'd2);
        bus.KEY[0] = 1'b0;
        bus.KEY[2] = 1'b0;
        step(5);
        check("prio_before", bus.PERIOD, 32'd8);
        step(1);
        check("prio_period", bus.PERIOD, 32'd4);
        check("prio_mode",   32'(bus.MODE), 32'd1);
        step(1);
        check("prio_ledr", 32'(bus.LEDR), 32'd0);
        check("prio_ledg", 32'(bus.LEDG), 32'd0);
        wait_tick(20, steps, ok);
        check("prio_tick_seen", 32'(ok), 32'd1);
        check("prio_cnt_cleared", 32'(steps), 32'd4);
        bus.KEY[0] = 1'b1;
        bus.KEY[2] = 1'b1;
        step(12);

`ifdef LED_SEQ_HOLD_EN
        // HOLD freezes counter, phase and mode
        begin
            int n_ticks;
            int n_led_changes;
            logic [7:0] g0;
            logic [9:0] r0;
            logic [1:0] m0;
            wait_tick(20, steps, ok);
            check("hold_pre_tick", 32'(ok), 32'd1);
            bus.HOLD = 1'b1;
            step(1);
            g0 = bus.LEDG;
            r0 = bus.LEDR;
            m0 = bus.MODE;
            n_ticks = 0;
            n_led_changes = 0;
            for (int i = 0; i < 49; i++) begin
                step(1);
                if (bus.TICK) n_ticks++;
                if (bus.LEDG != g0 || bus.LEDR != r0) n_led_changes++;
            end
            check("hold_no_tick", 32'(n_ticks), 32'd0);
            check("hold_led_static", 32'(n_led_changes), 32'd0);
            check("hold_mode_static", 32'(bus.MODE), 32'(m0));
            bus.HOLD = 1'b0;
            wait_tick(20, steps, ok);
            check("hold_resume_tick", 32'(ok), 32'd1);
            check("hold_resume_interval", 32'(steps), 32'd5);
        end
`endif

        // Reset mid-operation with KEY[0] held through it
        key_press(0, 6);
        check("pre_reset_period", bus.PERIOD, 32'd6);
        bus.KEY[0] = 1'b0;
        RESET = 1'b1;
        step(2);
        check("midreset_period", bus.PERIOD, 32'd4);
        check("midreset_mode",   32'(bus.MODE), 32'd1);
        check("midreset_tick",   32'(bus.TICK), 32'd0);
        RESET = 1'b0;
        step(5);
        check("post_reset_before", bus.PERIOD, 32'd4);
        step(1);
        check("post_reset_press", bus.PERIOD, 32'd6);
        step(40);
        check("post_reset_once", bus.PERIOD, 32'd6);
        bus.KEY[0] = 1'b1;
        step(12);
        check("post_reset_release", bus.PERIOD, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
